guess_game_ctrl: RTL and testbench

- Sequencing controller for the keypad number-guessing datapath.
- Consumes debounced, decoded key events and assembles a 3-digit BCD guess for the digit display.
- Compares the guess against a secret latched at game start, then drives result, try count, game-over flag and buzzer timing.
- Sits between the key decode stage and the digitron display driver.

---
 rtl/guess_game_ctrl.sv | 176 +++++++++++++++++
 tb/tb_guess_game_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_game_ctrl.sv
// guess_game_ctrl: sequencing controller for the keypad number-guessing game.
// Assembles a 3-digit BCD guess from decoded key events, compares it with a
// secret latched at NEWGAME, and drives result, try count, game-over and the
// buzzer timing. All outputs are registered.
// Optional build macro GUESS_BUZZ_PATTERN_EN: distinct buzzer patterns for
// wrong guess (1 beep), WIN (3 beeps) and LOSE (one 4-unit tone). Without it
// every outcome produces a single beep and the pattern counter is not built.
module guess_game_ctrl #(
    parameter int CLK_HZ    = 50000000,
    parameter int BEEP_MS   = 200,
    parameter int MAX_TRIES = 9
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [11:0] secret_bcd,
    output logic [11:0] data_disp,
    output logic [3:0]  tries,
    output logic [1:0]  result,
    output logic        game_over,
    output logic        buzzer
);

    localparam int BEEP_CYC = CLK_HZ / 1000 * BEEP_MS;
`ifdef GUESS_BUZZ_PATTERN_EN
    localparam int LONGEST  = 4 * BEEP_CYC;
`else
    localparam int LONGEST  = BEEP_CYC;
`endif
    localparam int CW = (LONGEST > 1) ? $clog2(LONGEST + 1) : 1;
    localparam logic [CW-1:0] BEEP_LAST = CW'(BEEP_CYC - 1);
    localparam logic [CW-1:0] LOSE_LAST = CW'(LONGEST - 1);

    localparam logic [3:0] KEY_CLEAR   = 4'd10;
    localparam logic [3:0] KEY_ENTER   = 4'd11;
    localparam logic [3:0] KEY_NEWGAME = 4'd12;

    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, FEEDBACK, WIN, LOSE} state_t;

    state_t          state;
    logic [11:0]     secret_q;
    logic [1:0]      entry_cnt;
    logic [CW-1:0]   beep_cnt;
`ifdef GUESS_BUZZ_PATTERN_EN
    logic [1:0]      beeps_left;   // on-pulses still to come after the current one
`endif

    logic            k_digit, k_clear, k_enter, k_newgame;
    logic            guess_eq, guess_lt;
    logic [3:0]      tries_next;
    logic            lose_now;
    logic            beep_done;

    // Key decode, digit-wise guess compare and try bookkeeping.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        k_digit   = key_valid && (key_code <= 4'd9);
        k_clear   = key_valid && (key_code == KEY_CLEAR);
        k_enter   = key_valid && (key_code == KEY_ENTER);
        k_newgame = key_valid && (key_code == KEY_NEWGAME);

        // MSD first; for valid BCD this is the numeric order.
        guess_eq = (data_disp == secret_q);
        guess_lt = (data_disp[11:8] < secret_q[11:8]) ||
                   ((data_disp[11:8] == secret_q[11:8]) &&
                    ((data_disp[7:4] < secret_q[7:4]) ||
                     ((data_disp[7:4] == secret_q[7:4]) &&
                      (data_disp[3:0] < secret_q[3:0]))));

        tries_next = (tries == 4'hF) ? tries : tries + 4'd1;
        lose_now   = (tries_next >= 4'(MAX_TRIES));

`ifdef GUESS_BUZZ_PATTERN_EN
        beep_done = buzzer && (beep_cnt == '0) && (beeps_left == 2'd0);
`else
        beep_done = buzzer && (beep_cnt == '0);
`endif
    end

    // Game FSM with registered outputs and the buzzer sequencer.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            // NOTE: the secret is a plain register, so it is reset like the rest;
            // nothing here is a RAM that would be left unreset.
            state     <= IDLE;
            secret_q  <= '0;
            entry_cnt <= '0;
            data_disp <= '0;
            tries     <= '0;
            result    <= '0;
            game_over <= 1'b0;
            buzzer    <= 1'b0;
            beep_cnt  <= '0;
`ifdef GUESS_BUZZ_PATTERN_EN
            beeps_left <= '0;
`endif
        end else if (k_newgame) begin
            state     <= ENTRY;
            secret_q  <= secret_bcd;
            entry_cnt <= '0;
            data_disp <= '0;
            tries     <= '0;
            result    <= '0;
            game_over <= 1'b0;
            buzzer    <= 1'b0;
            beep_cnt  <= '0;
`ifdef GUESS_BUZZ_PATTERN_EN
            beeps_left <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout; later ones in this block
            // (the CHECK branch) deliberately override the sequencer step.
`ifdef GUESS_BUZZ_PATTERN_EN
            if (buzzer || (beeps_left != 2'd0)) begin
                if (beep_cnt != '0) begin
                    beep_cnt <= beep_cnt - CW'(1);
                end else if (beeps_left == 2'd0) begin
                    buzzer <= 1'b0;
                end else begin
                    buzzer   <= !buzzer;
                    beep_cnt <= BEEP_LAST;
                    if (!buzzer) beeps_left <= beeps_left - 2'd1;
                end
            end
`else
            if (buzzer) begin
                if (beep_cnt == '0) buzzer <= 1'b0;
                else                beep_cnt <= beep_cnt - CW'(1);
            end
`endif
            case (state)
                ENTRY: begin
                    if (k_digit && (entry_cnt != 2'd3)) begin
                        data_disp <= {data_disp[7:0], key_code};
                        entry_cnt <= entry_cnt + 2'd1;
                    end else if (k_clear) begin
                        data_disp <= '0;
                        entry_cnt <= '0;
                    end else if (k_enter && (entry_cnt != 2'd0)) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    tries    <= tries_next;
                    result   <= guess_eq ? 2'b11 : (guess_lt ? 2'b01 : 2'b10);
                    buzzer   <= 1'b1;
                    beep_cnt <= BEEP_LAST;
                    if (guess_eq) begin
                        state     <= WIN;
                        data_disp <= secret_q;
`ifdef GUESS_BUZZ_PATTERN_EN
                        beeps_left <= 2'd2;
`endif
                    end else if (lose_now) begin
                        state     <= LOSE;
                        game_over <= 1'b1;
                        data_disp <= secret_q;
                        beep_cnt  <= LOSE_LAST;
                    end else begin
                        state <= FEEDBACK;
                    end
                end
                FEEDBACK: begin
                    if (beep_done) begin
                        state     <= ENTRY;
                        data_disp <= '0;
                        entry_cnt <= '0;
                    end
                end
                default: ;  // IDLE, WIN, LOSE wait for NEWGAME
            endcase
        end
    end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// tb_guess_game_ctrl: directed scenarios plus randomized key streams, each
// cycle compared against a game-level reference model (digit queue, decimal
// compare, buzzer derived from time since pattern start).
module tb_guess_game_ctrl;

    localparam int CLK_HZ    = 1000;
    localparam int BEEP_MS   = 4;
    localparam int MAX_TRIES = 3;
    localparam int BEEP      = CLK_HZ / 1000 * BEEP_MS;

    logic        clk = 1'b0;
    logic        RSTn = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [11:0] secret_bcd = 12'h000;
    logic [11:0] data_disp;
    logic [3:0]  tries;
    logic [1:0]  result;
    logic        game_over;
    logic        buzzer;

    guess_game_ctrl #(.CLK_HZ(CLK_HZ), .BEEP_MS(BEEP_MS), .MAX_TRIES(MAX_TRIES)) dut (
        .clk(clk), .RSTn(RSTn), .key_valid(key_valid), .key_code(key_code),
        .secret_bcd(secret_bcd), .data_disp(data_disp), .tries(tries),
        .result(result), .game_over(game_over), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {P_IDLE, P_ENTRY, P_CHECK, P_FEEDBACK, P_WIN, P_LOSE} phase_t;
    typedef enum {PAT_WRONG, PAT_WIN, PAT_LOSE} pat_t;

    phase_t      m_phase;
    int          m_digits[$];
    logic [11:0] m_secret;
    bit          m_show_secret;
    int          m_tries;
    int          m_result;
    bit          m_over;
    bit          m_pat_on;
    pat_t        m_pat;
    int          m_pat_t;

    function automatic int bcd_value(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic int pat_len(input pat_t p);
`ifdef GUESS_BUZZ_PATTERN_EN
        if (p == PAT_WIN)  return 5 * BEEP;
        if (p == PAT_LOSE) return 4 * BEEP;
`endif
        return BEEP;
    endfunction

    function automatic bit pat_level(input pat_t p, input int t);
`ifdef GUESS_BUZZ_PATTERN_EN
        if (p == PAT_WIN) return ((t / BEEP) % 2) == 0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [11:0] exp_disp();
        int v = 0;
        if (m_show_secret) return m_secret;
        foreach (m_digits[i]) v = v * 16 + m_digits[i];
        return 12'(v);
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_digits.delete(); m_secret = '0; m_show_secret = 0;
        m_tries = 0; m_result = 0; m_over = 0; m_pat_on = 0; m_pat = PAT_WRONG; m_pat_t = 0;
    endtask

    task automatic model_step(input bit v, input int c, input logic [11:0] sec);
        bit done = 0;
        int g = 0;
        int s;
        if (v && c == 12) begin
            model_reset();
            m_secret = sec;
            m_phase  = P_ENTRY;
            return;
        end
        if (m_pat_on) begin
            if (m_pat_t == pat_len(m_pat) - 1) begin m_pat_on = 0; done = 1; end
            else m_pat_t++;
        end
        case (m_phase)
            P_ENTRY: if (v) begin
                if (c < 10) begin
                    if (m_digits.size() < 3) m_digits.push_back(c);
                end else if (c == 10) m_digits.delete();
                else if (c == 11 && m_digits.size() > 0) m_phase = P_CHECK;
            end
            P_CHECK: begin
                foreach (m_digits[i]) g = g * 10 + m_digits[i];
                s = bcd_value(m_secret);
                if (m_tries < 15) m_tries++;
                m_result = (g == s) ? 3 : (g < s) ? 1 : 2;
                m_pat_on = 1; m_pat_t = 0;
                if (g == s) begin
                    m_phase = P_WIN; m_show_secret = 1; m_pat = PAT_WIN;
                end else if (m_tries >= MAX_TRIES) begin
                    m_phase = P_LOSE; m_show_secret = 1; m_over = 1; m_pat = PAT_LOSE;
                end else begin
                    m_phase = P_FEEDBACK; m_pat = PAT_WRONG;
                end
            end
            P_FEEDBACK: if (done) begin m_digits.delete(); m_phase = P_ENTRY; end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        check("data_disp", 32'(data_disp), 32'(exp_disp()));
        check("tries", 32'(tries), 32'(m_tries));
        check("result", 32'(result), 32'(m_result));
        check("game_over", 32'(game_over), 32'(m_over));
        check("buzzer", 32'(buzzer), 32'(m_pat_on && pat_level(m_pat, m_pat_t)));
    endtask

    // One clock: drive at negedge, model steps at posedge, compare at next negedge.
    task automatic tick(input bit v, input int c);
        key_valid = v;
        key_code  = 4'(c);
        @(posedge clk);
        model_step(v, c, secret_bcd);
        #1;
        key_valid = 1'b0;
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0);
    endtask

    task automatic guess(input int a, input int b, input int c);
        tick(1'b1, a); tick(1'b1, b); tick(1'b1, c); tick(1'b1, 11);
    endtask

    function automatic logic [11:0] rand_bcd();
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    initial begin
        model_reset();
        // Reset state
        @(negedge clk); @(negedge clk);
        compare_all();
        RSTn = 1'b1;
        @(negedge clk);
        compare_all();

        // No response before NEWGAME
        tick(1'b1, 5); tick(1'b1, 11); idle(3);
        check("idle_disp", 32'(data_disp), 32'h0);
        check("idle_result", 32'(result), 32'h0);

        // Entry, 4th digit ignored, CLEAR
        secret_bcd = 12'h527;
        tick(1'b1, 12);
        tick(1'b1, 3); check("disp_003", 32'(data_disp), 32'h003);
        tick(1'b1, 1); check("disp_031", 32'(data_disp), 32'h031);
        tick(1'b1, 2); check("disp_312", 32'(data_disp), 32'h312);
        tick(1'b1, 9); check("disp_4th", 32'(data_disp), 32'h312);
        tick(1'b1, 10); check("disp_clr", 32'(data_disp), 32'h000);

        // Too low: result at n+2, buzzer n+2..n+5, cleared after feedback
        guess(3, 1, 2);
        idle(1);
        check("low_result", 32'(result), 32'h1);
        check("low_tries", 32'(tries), 32'h1);
        check("low_buzz_on", 32'(buzzer), 32'h1);
        idle(3);
        check("low_buzz_last", 32'(buzzer), 32'h1);
        idle(1);
        check("low_buzz_off", 32'(buzzer), 32'h0);
        check("low_disp_clr", 32'(data_disp), 32'h000);

        // Too high then correct
        tick(1'b1, 12);
        guess(6, 0, 0); idle(1);
        check("high_result", 32'(result), 32'h2);
        idle(4);
        guess(5, 2, 7); idle(1);
        check("win_result", 32'(result), 32'h3);
        check("win_disp", 32'(data_disp), 32'h527);
        idle(24);
        tick(1'b1, 4);
        check("win_hold", 32'(data_disp), 32'h527);

        // Three wrong guesses -> LOSE
        tick(1'b1, 12);
        guess(1, 0, 0); idle(5);
        guess(2, 0, 0); idle(5);
        guess(3, 0, 0); idle(1);
        check("lose_over", 32'(game_over), 32'h1);
        check("lose_tries", 32'(tries), 32'h3);
        check("lose_disp", 32'(data_disp), 32'h527);
        idle(20);

        // Mid-beep asynchronous reset
        tick(1'b1, 12);
        guess(1, 0, 0); idle(2);
        check("pre_rst_buzz", 32'(buzzer), 32'h1);
        #2 RSTn = 1'b0;
        #1;
        model_reset();
        check("rst_buzz", 32'(buzzer), 32'h0);
        compare_all();
        @(negedge clk);
        RSTn = 1'b1;

        // NEWGAME during FEEDBACK
        tick(1'b1, 12);
        guess(9, 9, 9); idle(2);
        tick(1'b1, 12);
        check("ng_tries", 32'(tries), 32'h0);
        check("ng_result", 32'(result), 32'h0);
        tick(1'b1, 4);
        check("ng_entry", 32'(data_disp), 32'h004);

        // Randomized key streams
        for (int i = 0; i < 4000; i++) begin
            int r = $urandom_range(0, 99);
            secret_bcd = rand_bcd();
            if      (r < 55) tick(1'b1, $urandom_range(0, 9));
            else if (r < 65) tick(1'b1, 11);
            else if (r < 70) tick(1'b1, 10);
            else if (r < 73) tick(1'b1, 12);
            else if (r < 78) tick(1'b1, $urandom_range(13, 15));
            else             tick(1'b0, $urandom_range(0, 15));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
